// File: rtl/regfile_pkg.sv
// Shared register-file constants and the client naming used when the
// execution units are hooked onto the write-port arbiter.
package regfile_pkg;

  localparam int RF_NUM_REGS      = 32;
  localparam int RF_DATA_WIDTH    = 32;
  localparam int RF_REG_SEL_WIDTH = $clog2(RF_NUM_REGS);

  // Arbiter slot assignment of the execution units.
  typedef enum logic [1:0] {
    DIV = 2'd0,
    MUL = 2'd1,
    LSU = 2'd2,
    ALU = 2'd3
  } e_wr_client;

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of i_eligible at or above i_ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_eligible,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

  logic [2*N-1:0]   w_dbl;
  logic [2*N-1:0]   w_shift;
  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic             w_found;
  logic [IDX_W:0]   w_sum;

  // Duplicating the vector turns the wrap-around scan into a plain shift.
  assign w_dbl   = {i_eligible, i_eligible};
  assign w_shift = w_dbl >> i_ptr;
  assign w_rot   = w_shift[N-1:0];

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    w_found = 1'b0;
    w_off   = {IDX_W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = IDX_W'(k);
      end else begin
        w_found = w_found;
      end
    end
  end

  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};

  // Undo the rotation; N need not be a power of two, so wrap explicitly.
  always_comb begin
    o_found = w_found;
    if (w_sum >= N_W) begin
      o_idx = IDX_W'(w_sum - N_W);
    end else begin
      o_idx = IDX_W'(w_sum);
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: grants one requesting execution unit
// per cycle in round-robin order and drives the registered write port.
// A client whose ack is currently high is masked so its still-asserted
// request is not granted twice.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = RF_DATA_WIDTH,
  parameter int NUM_REGS       = RF_NUM_REGS,
  parameter int REG_SEL_WIDTH  = $clog2(NUM_REGS),
  parameter int REQ_IDX_WIDTH  = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQUESTERS-1:0]             i_req,
  input  logic [NUM_REQUESTERS*REG_SEL_WIDTH-1:0] i_req_sel,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]  i_req_data,
  output logic [NUM_REQUESTERS-1:0]             o_ack,
  output logic                                  o_rf_wr_en,
  output logic [REG_SEL_WIDTH-1:0]              o_rf_wr_sel,
  output logic [DATA_WIDTH-1:0]                 o_rf_wr_data,
  output logic [REQ_IDX_WIDTH-1:0]              o_grant_idx
);

  logic [NUM_REQUESTERS-1:0] r_ack;
  logic                      r_rf_wr_en;
  logic [REG_SEL_WIDTH-1:0]  r_rf_wr_sel;
  logic [DATA_WIDTH-1:0]     r_rf_wr_data;
  logic [REQ_IDX_WIDTH-1:0]  r_grant_idx;
  logic [REQ_IDX_WIDTH-1:0]  r_rr_ptr;

  logic [NUM_REQUESTERS-1:0] w_eligible;
  logic                      w_found;
  logic [REQ_IDX_WIDTH-1:0]  w_idx;
  logic [REQ_IDX_WIDTH-1:0]  w_ptr_next;
  logic [REG_SEL_WIDTH-1:0]  w_sel;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [NUM_REQUESTERS-1:0] w_onehot;

  assign w_eligible = i_req & ~r_ack;

  rr_pick #(
    .N     (NUM_REQUESTERS),
    .IDX_W (REQ_IDX_WIDTH)
  ) u_rr_pick (
    .i_eligible (w_eligible),
    .i_ptr      (r_rr_ptr),
    .o_found    (w_found),
    .o_idx      (w_idx)
  );

  assign w_sel    = i_req_sel[w_idx*REG_SEL_WIDTH +: REG_SEL_WIDTH];
  assign w_data   = i_req_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
  assign w_onehot = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << w_idx;

  // Priority moves to the slot just after the winner, wrapping at the last client.
  always_comb begin
    if (w_idx == REQ_IDX_WIDTH'(NUM_REQUESTERS - 1)) begin
      w_ptr_next = {REQ_IDX_WIDTH{1'b0}};
    end else begin
      w_ptr_next = w_idx + REQ_IDX_WIDTH'(1);
    end
  end

  // Grant and write-port registers; selector 0 is acked but never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack        <= {NUM_REQUESTERS{1'b0}};
      r_rf_wr_en   <= 1'b0;
      r_rf_wr_sel  <= {REG_SEL_WIDTH{1'b0}};
      r_rf_wr_data <= {DATA_WIDTH{1'b0}};
      r_grant_idx  <= {REQ_IDX_WIDTH{1'b0}};
      r_rr_ptr     <= {REQ_IDX_WIDTH{1'b0}};
    end else if (w_found) begin
      r_ack        <= w_onehot;
      r_rf_wr_en   <= (w_sel != {REG_SEL_WIDTH{1'b0}});
      r_rf_wr_sel  <= w_sel;
      r_rf_wr_data <= w_data;
      r_grant_idx  <= w_idx;
      r_rr_ptr     <= w_ptr_next;
    end else begin
      r_ack        <= {NUM_REQUESTERS{1'b0}};
      r_rf_wr_en   <= 1'b0;
      r_rf_wr_sel  <= {REG_SEL_WIDTH{1'b0}};
      r_rf_wr_data <= {DATA_WIDTH{1'b0}};
      r_grant_idx  <= r_grant_idx;
      r_rr_ptr     <= r_rr_ptr;
    end
  end

  assign o_ack        = r_ack;
  assign o_rf_wr_en   = r_rf_wr_en;
  assign o_rf_wr_sel  = r_rf_wr_sel;
  assign o_rf_wr_data = r_rf_wr_data;
  assign o_grant_idx  = r_grant_idx;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and randomized checks of the register-file write arbiter.
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, so each step spans exactly one rising edge of the DUT.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int RSW = 5;
  localparam int IW  = 2;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*RSW-1:0] req_sel;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic              wr_en;
  logic [RSW-1:0]    wr_sel;
  logic [DW-1:0]     wr_data;
  logic [IW-1:0]     gidx;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wr_arbiter #(
    .NUM_REQUESTERS (NR),
    .DATA_WIDTH     (DW),
    .NUM_REGS       (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (req),
    .i_req_sel    (req_sel),
    .i_req_data   (req_data),
    .o_ack        (ack),
    .o_rf_wr_en   (wr_en),
    .o_rf_wr_sel  (wr_sel),
    .o_rf_wr_data (wr_data),
    .o_grant_idx  (gidx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_port(input string tag, input logic [3:0] a, input logic e,
                          input logic [4:0] s, input logic [31:0] d);
    chk_eq({tag, "_ack"}, 64'(ack), 64'(a));
    chk_eq({tag, "_en"}, 64'(wr_en), 64'(e));
    chk_eq({tag, "_sel"}, 64'(wr_sel), 64'(s));
    chk_eq({tag, "_data"}, 64'(wr_data), 64'(d));
  endtask

  task automatic set_client(input int i, input logic r, input logic [4:0] s, input logic [31:0] d);
    req[i] = r;
    req_sel[i*RSW +: RSW] = s;
    req_data[i*DW +: DW] = d;
  endtask

  // random-phase model state
  logic [NR-1:0] pend, seen, elig, exp_ack;
  logic [4:0]    msel [NR];
  logic [31:0]   mdat [NR];
  logic          exp_en, found;
  logic [4:0]    exp_sel;
  logic [31:0]   exp_data;
  int            exp_gidx, mptr, w, n_req, dut_acks, max_wait;
  int            waitc [NR];

  initial begin
    rst = 1'b1; req = '0; req_sel = '0; req_data = '0;
    repeat (2) @(negedge clk);
    chk_port("reset", 4'b0000, 1'b0, 5'd0, 32'd0);
    chk_eq("reset_gidx", 64'(gidx), 64'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_eq("idle_ack", 64'(ack), 64'd0);
      chk_eq("idle_en", 64'(wr_en), 64'd0);
    end

    // single client, held through its ack cycle: no second grant
    set_client(2, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk_port("c2", 4'b0100, 1'b1, 5'd5, 32'hDEADBEEF);
    chk_eq("c2_gidx", 64'(gidx), 64'd2);
    @(negedge clk);
    chk_port("c2_hold", 4'b0000, 1'b0, 5'd0, 32'd0);
    chk_eq("c2_hold_gidx", 64'(gidx), 64'd2);
    set_client(2, 1'b0, 5'd0, 32'd0);

    // reset while a grant is showing
    set_client(1, 1'b1, 5'd7, 32'h77);
    @(negedge clk);
    chk_port("c1", 4'b0010, 1'b1, 5'd7, 32'h77);
    #2 rst = 1'b1;
    #1 chk_port("rst_mid", 4'b0000, 1'b0, 5'd0, 32'd0);
    chk_eq("rst_mid_gidx", 64'(gidx), 64'd0);
    set_client(1, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // all four requesting continuously: 0,1,2,3,0
    for (int i = 0; i < NR; i++) set_client(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_port("rr", 4'b0001 << (k % 4), 1'b1, 5'((k % 4) + 1), 32'h100 + 32'(k % 4));
      chk_eq("rr_gidx", 64'(gidx), 64'(k % 4));
    end
    for (int i = 1; i < NR; i++) set_client(i, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk_port("rr_end", 4'b0000, 1'b0, 5'd0, 32'd0);
    set_client(0, 1'b0, 5'd0, 32'd0);

    // write to x0: acked, not performed
    set_client(1, 1'b1, 5'd0, 32'h55);
    @(negedge clk);
    chk_port("x0", 4'b0010, 1'b0, 5'd0, 32'h55);
    chk_eq("x0_gidx", 64'(gidx), 64'd1);
    @(negedge clk);
    chk_eq("x0_hold_ack", 64'(ack), 64'd0);
    set_client(1, 1'b0, 5'd0, 32'd0);

    // divider quotient then modulus, ALU competing; pointer now at 2
    set_client(int'(DIV), 1'b1, 5'd3, 32'd7);
    set_client(int'(ALU), 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    chk_port("div_a", 4'b1000, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    chk_port("div_b", 4'b0001, 1'b1, 5'd3, 32'd7);
    set_client(int'(ALU), 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk_port("div_c", 4'b0000, 1'b0, 5'd0, 32'd0);
    set_client(int'(DIV), 1'b1, 5'd4, 32'd1);
    @(negedge clk);
    chk_port("div_d", 4'b0001, 1'b1, 5'd4, 32'd1);
    @(negedge clk);
    chk_port("div_e", 4'b0000, 1'b0, 5'd0, 32'd0);
    set_client(int'(DIV), 1'b0, 5'd0, 32'd0);

    // random stress against a round-robin reference
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pend = '0; seen = '0; exp_ack = '0; exp_en = 1'b0; exp_sel = '0; exp_data = '0;
    exp_gidx = 0; mptr = 0; n_req = 0; dut_acks = 0; max_wait = 0;
    for (int i = 0; i < NR; i++) begin msel[i] = '0; mdat[i] = '0; waitc[i] = 0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      chk_port("rnd", exp_ack, exp_en, exp_sel, exp_data);
      chk_eq("rnd_gidx", 64'(gidx), 64'(exp_gidx));
      dut_acks += $countones(ack);
      for (int i = 0; i < NR; i++) begin
        if (seen[i]) pend[i] = 1'b0;
        if (!pend[i] && cyc < 280 && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          msel[i] = 5'($urandom_range(0, 31));
          mdat[i] = $urandom;
          n_req++;
        end
        set_client(i, pend[i], msel[i], mdat[i]);
      end
      seen = exp_ack;
      elig = pend & ~exp_ack;
      found = 1'b0;
      w = 0;
      for (int k = 0; k < NR; k++) begin
        if (!found && elig[(mptr + k) % NR]) begin
          found = 1'b1;
          w = (mptr + k) % NR;
        end
      end
      if (found) begin
        exp_ack = 4'b0001 << w; exp_sel = msel[w]; exp_data = mdat[w];
        exp_en = (msel[w] != 5'd0); exp_gidx = w; mptr = (w + 1) % NR;
      end else begin
        exp_ack = '0; exp_sel = '0; exp_data = '0; exp_en = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (elig[i] && !(found && w == i)) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > max_wait) max_wait = waitc[i];
      end
      @(negedge clk);
    end
    chk_eq("rnd_all_acked_once", 64'(dut_acks), 64'(n_req));
    chk_eq("rnd_wait_bound", 64'(max_wait < NR), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
